// File: rtl/fwd_hazard_unit.sv
// Operand-forwarding select and load-use hazard detection for the EX stage.
// Tracks the destination of each in-flight instruction for DEPTH stages after EX.
module fwd_hazard_unit #(
  parameter int unsigned NUM_READ   = 2,
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned LOAD_DELAY = 1,
  parameter int unsigned CNT_W      = 32,
  localparam int unsigned SELW      = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ex_valid,
  input  logic                     ex_we,
  input  logic                     ex_is_load,
  input  logic [4:0]               ex_rd,
  input  logic [5*NUM_READ-1:0]    ex_rs,
  input  logic [NUM_READ-1:0]      ex_rs_used,
  input  logic                     ex_flush,
  input  logic                     cnt_clear,
  output logic [SELW*NUM_READ-1:0] fwd_sel,
  output logic                     stall,
  output logic [CNT_W-1:0]         stall_cnt,
  output logic [CNT_W-1:0]         fwd_cnt
);

  // Index i of the tracker holds stage k = i + 1.
  logic [DEPTH-1:0]      valid_q, valid_d;
  logic [DEPTH-1:0]      we_q, we_d;
  logic [DEPTH-1:0]      ld_q, ld_d;
  logic [DEPTH-1:0][4:0] rd_q, rd_d;

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] fwd_cnt_q, fwd_cnt_d;

  logic [NUM_READ-1:0][SELW-1:0] sel_raw;
  logic [NUM_READ-1:0]           hazard;
  logic                          stall_w;
  logic                          any_fwd;

  // Scan oldest to youngest so the youngest producer overwrites older matches.
  always_comb begin
    sel_raw = '0;
    hazard  = '0;
    for (int p = 0; p < NUM_READ; p++) begin
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (ex_valid && ex_rs_used[p] && valid_q[k] && we_q[k] && (rd_q[k] != 5'd0) &&
            (rd_q[k] == ex_rs[5*p +: 5])) begin
          sel_raw[p] = SELW'(k + 1);
          hazard[p]  = ld_q[k] && (int'(LOAD_DELAY) >= k + 1);
        end
      end
    end
  end

  always_comb begin
    stall_w = (|hazard) && !ex_flush;
    fwd_sel = stall_w ? '0 : sel_raw;
    any_fwd = |fwd_sel;
  end

  always_comb begin
    valid_d = '0;
    we_d    = '0;
    ld_d    = '0;
    rd_d    = '0;
    if (!stall_w && !ex_flush) begin
      valid_d[0] = ex_valid;
      we_d[0]    = ex_we;
      ld_d[0]    = ex_is_load;
      rd_d[0]    = ex_rd;
    end
    for (int k = 1; k < DEPTH; k++) begin
      valid_d[k] = valid_q[k-1];
      we_d[k]    = we_q[k-1];
      ld_d[k]    = ld_q[k-1];
      rd_d[k]    = rd_q[k-1];
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    fwd_cnt_d   = fwd_cnt_q;
    if (cnt_clear) begin
      stall_cnt_d = '0;
      fwd_cnt_d   = '0;
    end else begin
      if (stall_w && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
      if (any_fwd && (fwd_cnt_q != '1))   fwd_cnt_d   = fwd_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= '0;
      we_q        <= '0;
      ld_q        <= '0;
      rd_q        <= '0;
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      valid_q     <= valid_d;
      we_q        <= we_d;
      ld_q        <= ld_d;
      rd_q        <= rd_d;
      stall_cnt_q <= stall_cnt_d;
      fwd_cnt_q   <= fwd_cnt_d;
    end
  end

  assign stall     = stall_w;
  assign stall_cnt = stall_cnt_q;
  assign fwd_cnt   = fwd_cnt_q;

endmodule

// File: doc/fwd_hazard_unit.md
FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

Interface
REQ-001 SHALL have parameter NUM_READ, default 2: number of EX-stage source-register ports.
REQ-002 SHALL have parameter DEPTH, default 2: tracked stages after EX; stage 1 = MEM, stage DEPTH = WB.
REQ-003 SHALL have parameter LOAD_DELAY, default 1: a load result is forwardable only from stage k > LOAD_DELAY; 0 <= LOAD_DELAY < DEPTH.
REQ-004 SHALL have parameter CNT_W, default 32: width of the performance counters.
REQ-005 SHALL define SELW = clog2(DEPTH+1).
REQ-006 Ports, in this order:
- clk  in  1  clock; one clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ex_valid  in  1  EX holds a real instruction.
- ex_we  in  1  EX instruction writes rd.
- ex_is_load  in  1  EX instruction is a load.
- ex_rd  in  5  EX destination register.
- ex_rs  in  5*NUM_READ  EX source registers; port p = bits [5p+4:5p].
- ex_rs_used  in  NUM_READ  port p actually reads its rs.
- ex_flush  in  1  squash the EX instruction this cycle.
- cnt_clear  in  1  synchronous clear of both counters.
- fwd_sel  out  SELW*NUM_READ  per-port source: 0 = register file, k = stage k.
- stall  out  1  hold ID/EX; insert bubble.
- stall_cnt  out  CNT_W  saturating count of stall cycles.
- fwd_cnt  out  CNT_W  saturating count of cycles with at least one non-zero fwd_sel.

Function
REQ-007 SHALL hold a DEPTH-entry tracker; each entry = {valid, we, is_load, rd}.
REQ-008 Entry k is a producer for port p iff: valid && we && rd != 0 && rd == ex_rs[p] && ex_rs_used[p] && ex_valid.
REQ-009 The match for port p SHALL be the lowest-k producer (youngest wins); all older matches are ignored.
REQ-010 fwd_sel[p] SHALL equal the matched k, or 0 when there is no match.
REQ-011 fwd_sel[p] SHALL be 0 while stall is high.
REQ-012 A port hazard SHALL exist iff the matched entry has is_load = 1 and k <= LOAD_DELAY.
REQ-013 stall SHALL be the OR of all port hazards, gated low when ex_flush = 1.
REQ-014 stall, fwd_sel, and the hazard logic SHALL be combinational from the current tracker contents and inputs (zero latency).
REQ-015 Each rising edge, entry k SHALL load entry k-1 for k = 2..DEPTH; the former entry DEPTH is discarded.
REQ-016 Each rising edge, entry 1 SHALL load {ex_valid, ex_we, ex_is_load, ex_rd} when stall = 0 and ex_flush = 0; otherwise it SHALL load a bubble (all fields 0).
REQ-017 The same producer SHALL stall at most LOAD_DELAY consecutive cycles, since it advances one stage per cycle regardless of stall.
REQ-018 ex_flush SHALL affect only entry 1; entries 2..DEPTH advance normally.
REQ-019 stall_cnt SHALL increment by 1 on each edge with stall = 1, saturating at all-ones.
REQ-020 fwd_cnt SHALL increment by 1 on each edge with any fwd_sel != 0, saturating at all-ones.
REQ-021 cnt_clear SHALL zero both counters on the next edge and take priority over increment.
REQ-022 ex_rd = 0 SHALL never match, including for loads (x0 is never a producer).

Reset
REQ-023 rst_n low SHALL asynchronously clear all tracker entries and both counters to 0, including mid-stall.
REQ-024 During reset, all outputs SHALL be 0.
REQ-025 The first edge after rst_n rises SHALL behave as a normal cycle.

Verification
REQ-026 Defaults. ALU writes x5, then the next EX reads rs0 = x5 -> fwd_sel[0] = 1, stall = 0. One cycle later, with an unrelated instruction between, the same read -> fwd_sel[0] = 2.
REQ-027 Youngest wins. Stages 1 and 2 both write x7; EX reads rs0 = rs1 = x7 -> both sel = 1.
REQ-028 Load-use. Load x3 enters stage 1; EX reads x3 -> stall = 1 for exactly 1 cycle, entry 1 = bubble, then fwd_sel = 2, stall_cnt = 1. With LOAD_DELAY = 2 and DEPTH = 3 -> stall = 1 for 2 cycles.
REQ-029 Gating. Load x3 in stage 1 with ex_flush = 1 -> stall = 0 and entry 1 = bubble next cycle. A match with ex_rs_used = 0 or rd = x0 -> sel = 0.
REQ-030 Counters. stall_cnt preset near all-ones via stall cycles (CNT_W = 4) -> saturates at 15. cnt_clear while stall = 1 -> counter = 0.
REQ-031 Reset. rst_n pulsed low mid-stall, asynchronously between edges -> stall, fwd_sel, and counters drop to 0 immediately; tracker is empty afterwards.
